// File: rtl/timer_sched.sv
// Multi-channel tick-driven timer scheduler: each channel counts down a programmable
// period in ticks, emits a one-cycle expire pulse and optionally reloads.
module timer_sched #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    pause,
  input  logic                    cfg_we,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic [W-1:0]            cfg_period,
  input  logic                    cfg_periodic,
  input  logic [NCH-1:0]          start,
  input  logic [NCH-1:0]          stop,
  output logic [NCH-1:0]          expire,
  output logic [NCH-1:0]          active,
  input  logic [$clog2(NCH)-1:0]  rd_ch,
  output logic [W-1:0]            rd_count
);

  localparam int CW = $clog2(NCH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e         state_q    [NCH];
  state_e         state_d    [NCH];
  logic [W-1:0]   period_q   [NCH];
  logic [W-1:0]   period_d   [NCH];
  logic [W-1:0]   count_q    [NCH];
  logic [W-1:0]   count_d    [NCH];
  logic [NCH-1:0] periodic_q;
  logic [NCH-1:0] periodic_d;
  logic [NCH-1:0] expire_q;
  logic [NCH-1:0] expire_d;
  logic [NCH-1:0] active_q;
  logic [NCH-1:0] active_d;

  logic [NCH-1:0] wr_hit;
  logic [W-1:0]   eff_period [NCH];
  logic           tick_ok;

  assign tick_ok = tick & ~pause;

  // A same-cycle config write is visible to a start (write-through) but not to a reload.
  for (genvar g = 0; g < NCH; g++) begin : g_eff
    assign wr_hit[g]     = cfg_we && (cfg_ch == CW'(g));
    assign eff_period[g] = wr_hit[g] ? cfg_period : period_q[g];
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned, which would infer a latch.
    periodic_d = periodic_q;
    expire_d   = '0;
    active_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      period_d[i] = eff_period[i];
      if (wr_hit[i]) periodic_d[i] = cfg_periodic;

      if (stop[i]) begin
        state_d[i] = IDLE;
        count_d[i] = '0;
      end else if (start[i] && (eff_period[i] != '0)) begin
        state_d[i] = RUN;
        count_d[i] = eff_period[i];
      end else if ((state_q[i] == RUN) && tick_ok) begin
        if (count_q[i] > W'(1)) begin
          count_d[i] = count_q[i] - W'(1);
        end else begin
          expire_d[i] = 1'b1;
          if (periodic_q[i] && (period_q[i] != '0)) begin
            count_d[i] = period_q[i];
          end else begin
            state_d[i] = IDLE;
            count_d[i] = '0;
          end
        end
      end
      active_d[i] = (state_d[i] == RUN);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      periodic_q <= '0;
      expire_q   <= '0;
      active_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= IDLE;
        period_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      periodic_q <= periodic_d;
      expire_q   <= expire_d;
      active_q   <= active_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= state_d[i];
        period_q[i] <= period_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  assign expire   = expire_q;
  assign active   = active_q;
  assign rd_count = count_q[rd_ch];

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with hand-computed expectations.
module tb_timer_sched;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           tick;
  logic           pause;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [W-1:0]   cfg_period;
  logic           cfg_periodic;
  logic [NCH-1:0] start;
  logic [NCH-1:0] stop;
  logic [NCH-1:0] expire;
  logic [NCH-1:0] active;
  logic [1:0]     rd_ch;
  logic [W-1:0]   rd_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [NCH-1:0] exp_seen;

  timer_sched #(.NCH(NCH), .W(W)) dut (
    .clk(clk), .reset(reset), .tick(tick), .pause(pause),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_periodic(cfg_periodic),
    .start(start), .stop(stop), .expire(expire), .active(active),
    .rd_ch(rd_ch), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change #1 after the edge, and pulse inputs fall back to 0.
  task automatic cyc();
    @(posedge clk);
    #1;
    tick   = 1'b0;
    start  = '0;
    stop   = '0;
    cfg_we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [W-1:0] per, input logic mode);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = per; cfg_periodic = mode;
    cyc();
  endtask

  task automatic strt(input logic [NCH-1:0] m);
    start = m;
    cyc();
  endtask

  task automatic tk();
    tick = 1'b1;
    cyc();
  endtask

  initial begin
    reset = 1'b1; tick = 0; pause = 0; cfg_we = 0; cfg_ch = 0; cfg_period = 0;
    cfg_periodic = 0; start = 0; stop = 0; rd_ch = 0;
    cyc(); cyc();
    reset = 1'b0;
    check("rst_expire", 32'(expire), 0);
    check("rst_active", 32'(active), 0);
    check("rst_count", 32'(rd_count), 0);

    // One-shot, period 3, ticks spaced 5 cycles apart
    rd_ch = 0;
    wr(0, 3, 0);
    strt(4'b0001);
    check("os_active", 32'(active[0]), 1);
    check("os_load", 32'(rd_count), 3);
    exp_seen = '0;
    for (int k = 1; k <= 3; k++) begin
      tk();
      if (k < 3) begin
        exp_seen |= expire;
        for (int j = 0; j < 4; j++) cyc();
      end
    end
    check("os_early_expire", 32'(exp_seen[0]), 0);
    check("os_expire", 32'(expire[0]), 1);
    cyc();
    check("os_pulse_len", 32'(expire[0]), 0);
    check("os_idle", 32'(active[0]), 0);
    check("os_count0", 32'(rd_count), 0);

    // Periodic, period 2: expiries after ticks 2, 4, 6
    rd_ch = 1;
    wr(1, 2, 1);
    strt(4'b0010);
    for (int k = 1; k <= 6; k++) begin
      tk();
      check($sformatf("per_tick%0d", k), 32'(expire[1]), (k % 2 == 0) ? 1 : 0);
    end
    check("per_active", 32'(active[1]), 1);
    check("per_reload", 32'(rd_count), 2);
    stop = 4'b0010; cyc();
    check("per_stopped", 32'(active[1]), 0);

    // Pause discards ticks
    rd_ch = 2;
    wr(2, 4, 0);
    strt(4'b0100);
    tk(); tk();
    check("pz_pre", 32'(rd_count), 2);
    pause = 1'b1;
    exp_seen = '0;
    for (int k = 0; k < 3; k++) begin
      tk();
      exp_seen |= expire;
    end
    check("pz_count_held", 32'(rd_count), 2);
    check("pz_no_expire", 32'(exp_seen), 0);
    pause = 1'b0;
    tk();
    check("pz_count1", 32'(rd_count), 1);
    tk();
    check("pz_expire", 32'(expire[2]), 1);

    // Collisions
    rd_ch = 0;
    wr(0, 2, 0);
    strt(4'b0001);
    tk();
    check("col_cnt1", 32'(rd_count), 1);
    tick = 1'b1; stop = 4'b0001; cyc();
    check("col_stop_noexp", 32'(expire[0]), 0);
    check("col_stop_idle", 32'(active[0]), 0);
    check("col_stop_cnt", 32'(rd_count), 0);
    strt(4'b1000);
    check("col_zero_period", 32'(active[3]), 0);
    wr(0, 5, 0);
    strt(4'b0001);
    tk(); tk();
    check("col_cnt3", 32'(rd_count), 3);
    tick = 1'b1; start = 4'b0001; cyc();
    check("col_restart", 32'(rd_count), 5);
    stop = 4'b0001; cyc();

    // Reconfiguration of a running channel
    rd_ch = 3;
    wr(3, 5, 1);
    strt(4'b1000);
    tk(); tk();
    wr(3, 2, 1);
    check("rc_count_kept", 32'(rd_count), 3);
    tk(); tk();
    check("rc_no_early", 32'(expire[3]), 0);
    tk();
    check("rc_expire1", 32'(expire[3]), 1);
    check("rc_new_period", 32'(rd_count), 2);
    tk();
    check("rc_mid", 32'(expire[3]), 0);
    tk();
    check("rc_expire2", 32'(expire[3]), 1);
    cfg_we = 1'b1; cfg_ch = 3; cfg_period = 7; cfg_periodic = 1; start = 4'b1000; cyc();
    check("rc_writethru", 32'(rd_count), 7);
    // Periodic channel whose period is zeroed before reload retires to IDLE
    wr(3, 0, 1);
    for (int k = 0; k < 7; k++) tk();
    check("rc_zero_reload_exp", 32'(expire[3]), 1);
    check("rc_zero_reload_idle", 32'(active[3]), 0);

    // Reset mid-count
    for (int c = 0; c < NCH; c++) wr(2'(c), 9, 1);
    strt(4'b1111);
    tk();
    check("rs_all_active", 32'(active), 32'hf);
    reset = 1'b1; tick = 1'b1; start = 4'b1111; cyc();
    reset = 1'b0;
    check("rs_expire", 32'(expire), 0);
    check("rs_active", 32'(active), 0);
    for (int c = 0; c < NCH; c++) begin
      rd_ch = 2'(c);
      #1;
      check($sformatf("rs_count%0d", c), 32'(rd_count), 0);
    end
    strt(4'b0001);
    check("rs_start_ignored", 32'(active), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
